// File: rtl/input_debounce_filter.sv
// Per-bit debounce filter: two-flop synchroniser, prescaled sampling and an N-consecutive-sample acceptance counter.
// Optional edge pulses built only when INPUT_DEBOUNCE_EDGE_PULSE_EN is defined; otherwise risePulse/fallPulse are tied low.
module input_debounce_channel #(
  parameter int STABLE_SAMPLES = 8,
  parameter bit INIT_LEVEL     = 1'b0
) (
  input  logic masterClk,
  input  logic reset,
  input  logic rawBit,
  input  logic sampleTick,
  output logic level,
  output logic risePulse,
  output logic fallPulse
);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);

  logic          meta, sync;
  logic [CW-1:0] count;
  logic          differ, accept;

  assign differ = sync != level;
  // The sample that completes the run is the one taking count to STABLE_SAMPLES.
  assign accept = sampleTick && differ && (count == CW'(STABLE_SAMPLES - 1));

  always_ff @(posedge masterClk or posedge reset) begin
    if (reset) begin
      meta  <= INIT_LEVEL;
      sync  <= INIT_LEVEL;
      level <= INIT_LEVEL;
      count <= '0;
    end else begin
      meta <= rawBit;
      sync <= meta;
      if (sampleTick) begin
        if (!differ) begin
          count <= '0;
        end else if (accept) begin
          level <= sync;
          count <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

`ifdef INPUT_DEBOUNCE_EDGE_PULSE_EN
  always_ff @(posedge masterClk or posedge reset) begin
    if (reset) begin
      risePulse <= 1'b0;
      fallPulse <= 1'b0;
    end else begin
      risePulse <= accept && sync;
      fallPulse <= accept && !sync;
    end
  end
`else
  assign risePulse = 1'b0;
  assign fallPulse = 1'b0;
`endif
endmodule

module input_debounce_filter #(
  parameter int WIDTH          = 8,
  parameter int CLK_DIV        = 3000,
  parameter int STABLE_SAMPLES = 8,
  parameter int INIT_LEVEL     = 0
) (
  input  logic             masterClk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rawInput,
  output logic [WIDTH-1:0] debouncedOutput,
  output logic [WIDTH-1:0] risePulse,
  output logic [WIDTH-1:0] fallPulse,
  output logic             sampleTick
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] prescaler;

  always_ff @(posedge masterClk or posedge reset) begin
    if (reset)                               prescaler <= '0;
    else if (prescaler == PW'(CLK_DIV - 1))  prescaler <= '0;
    else                                     prescaler <= prescaler + PW'(1);
  end

  // Gated by reset so CLK_DIV=1 does not strobe while held in reset.
  assign sampleTick = (prescaler == PW'(CLK_DIV - 1)) && !reset;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    input_debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .INIT_LEVEL    (INIT_LEVEL != 0)
    ) u_chan (
      .masterClk (masterClk),
      .reset     (reset),
      .rawBit    (rawInput[i]),
      .sampleTick(sampleTick),
      .level     (debouncedOutput[i]),
      .risePulse (risePulse[i]),
      .fallPulse (fallPulse[i])
    );
  end
endmodule

// File: tb/tb_input_debounce_filter.sv
// Scoreboard bench for input_debounce_filter (WIDTH=4, CLK_DIV=4, STABLE_SAMPLES=3).
// Pulse expectations follow whether INPUT_DEBOUNCE_EDGE_PULSE_EN is defined for the build.
module tb_input_debounce_filter;
  localparam int W = 4;
`ifdef INPUT_DEBOUNCE_EDGE_PULSE_EN
  localparam logic [W-1:0] PM = 4'hF;
`else
  localparam logic [W-1:0] PM = 4'h0;
`endif

  typedef struct {
    logic [W-1:0] dout, rise, fall;
    int           lo, hi;
  } exp_t;

  logic         masterClk = 1'b0, clkEn = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] rawInput = '0;
  logic [W-1:0] debouncedOutput, risePulse, fallPulse;
  logic         sampleTick;

  int   cyc = 0, total = 0, bad = 0;
  exp_t sbq[$];
  exp_t mexp;
  logic [W-1:0] lastDout = '0;

  input_debounce_filter #(.WIDTH(W), .CLK_DIV(4), .STABLE_SAMPLES(3), .INIT_LEVEL(0)) dut (
    .masterClk      (masterClk),
    .reset          (reset),
    .rawInput       (rawInput),
    .debouncedOutput(debouncedOutput),
    .risePulse      (risePulse),
    .fallPulse      (fallPulse),
    .sampleTick     (sampleTick)
  );

  always begin
    #5;
    if (clkEn) masterClk = ~masterClk;
  end

  always @(posedge masterClk) cyc++;

  // Monitor: every output change pops one expectation; no pulse may appear without a change.
  always @(negedge masterClk) begin
    if (reset) begin
      total++;
      if ((risePulse | fallPulse) !== '0) begin
        bad++; $display("FAIL pulse_in_reset got rise=%b fall=%b want 0", risePulse, fallPulse);
      end
      lastDout = debouncedOutput;
    end else if (debouncedOutput !== lastDout) begin
      total++;
      if (sbq.size() == 0) begin
        bad++; $display("FAIL unexpected_change cyc=%0d got dout=%b was %b", cyc, debouncedOutput, lastDout);
      end else begin
        mexp = sbq.pop_front();
        total += 3;
        if (debouncedOutput !== mexp.dout) begin
          bad++; $display("FAIL dout got %b want %b", debouncedOutput, mexp.dout);
        end
        if (risePulse !== mexp.rise || fallPulse !== mexp.fall) begin
          bad++; $display("FAIL edge_pulse got rise=%b fall=%b want rise=%b fall=%b",
                          risePulse, fallPulse, mexp.rise, mexp.fall);
        end
        if (cyc < mexp.lo || cyc > mexp.hi) begin
          bad++; $display("FAIL latency change at cyc %0d want %0d..%0d", cyc, mexp.lo, mexp.hi);
        end
      end
      lastDout = debouncedOutput;
    end else begin
      total++;
      if ((risePulse | fallPulse) !== '0) begin
        bad++; $display("FAIL spurious_pulse cyc=%0d got rise=%b fall=%b want 0", cyc, risePulse, fallPulse);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    rawInput = '0;
    repeat (2) @(negedge masterClk);
    #1 reset = 1'b0;
    repeat (2) @(negedge masterClk);
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge masterClk);
      if (sampleTick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_drain(output bit ok);
    for (int n = 0; n < 40 && sbq.size() != 0; n++) begin
      @(negedge masterClk); #1;
    end
    ok = (sbq.size() == 0);
    repeat (2) @(negedge masterClk);
  endtask

  task automatic test_reset();
    int start;
    logic [3:0] tickSeen, tickWant;
    #2 reset = 1'b1;
    #1;
    total++;
    if (debouncedOutput !== 4'b0000 || risePulse !== 4'b0000 || fallPulse !== 4'b0000 || sampleTick !== 1'b0) begin
      bad++; $display("FAIL reset_noclk got dout=%b rise=%b fall=%b tick=%b want 0000/0000/0000/0",
                      debouncedOutput, risePulse, fallPulse, sampleTick);
    end
    clkEn = 1'b1;
    repeat (3) @(negedge masterClk);
    total++;
    if (debouncedOutput !== 4'b0000 || sampleTick !== 1'b0) begin
      bad++; $display("FAIL reset_held got dout=%b tick=%b want 0000/0", debouncedOutput, sampleTick);
    end
    #1 reset = 1'b0;
    start = cyc;
    // Tick is high in the cycle ending at the 4th edge after release.
    tickWant = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge masterClk);
      tickSeen[k] = sampleTick;
      total++;
      if (tickSeen[k] !== tickWant[k] || cyc != start + k + 1) begin
        bad++; $display("FAIL first_tick edge %0d got %b want %b", k + 1, tickSeen[k], tickWant[k]);
      end
    end
  endtask

  task automatic test_step();
    int start;
    bit ok;
    do_reset();
    @(negedge masterClk);
    rawInput = 4'b0001;
    start = cyc;
    sbq.push_back('{dout: 4'b0001, rise: 4'b0001 & PM, fall: 4'b0000, lo: start + 11, hi: start + 14});
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL step_timeout got pending=%0d want 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_glitch();
    int start;
    bit ok;
    do_reset();
    wait_tick(ok);
    rawInput = 4'b0010;
    repeat (8) @(negedge masterClk);
    rawInput = 4'b0000;
    repeat (30) @(negedge masterClk);
    total++;
    if (!ok || debouncedOutput !== 4'b0000) begin
      bad++; $display("FAIL glitch_reject got dout=%b tickok=%0d want 0000/1", debouncedOutput, ok);
    end
    // Samples 1,0,1,1,1: only the final three highs may accept.
    wait_tick(ok);
    rawInput = 4'b0010;
    start = cyc;
    sbq.push_back('{dout: 4'b0010, rise: 4'b0010 & PM, fall: 4'b0000, lo: start + 21, hi: start + 21});
    repeat (4) @(negedge masterClk);
    rawInput = 4'b0000;
    repeat (4) @(negedge masterClk);
    rawInput = 4'b0010;
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pattern_timeout got pending=%0d want 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_back_to_back();
    int start;
    bit ok;
    do_reset();
    rawInput = 4'b1100;
    start = cyc;
    sbq.push_back('{dout: 4'b1100, rise: 4'b1100 & PM, fall: 4'b0000, lo: start + 11, hi: start + 14});
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL multi_rise_timeout got pending=%0d want 0", sbq.size()); sbq.delete(); end
    rawInput = 4'b0100;
    start = cyc;
    sbq.push_back('{dout: 4'b0100, rise: 4'b0000, fall: 4'b1000 & PM, lo: start + 11, hi: start + 14});
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL multi_fall_timeout got pending=%0d want 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_reset_midcount();
    int start;
    bit ok;
    do_reset();
    wait_tick(ok);
    rawInput = 4'b0100;
    repeat (9) @(negedge masterClk);   // two differing samples taken on bit 2
    #1 reset = 1'b1;
    #1;
    total++;
    if (!ok || debouncedOutput !== 4'b0000 || risePulse !== 4'b0000 || sampleTick !== 1'b0) begin
      bad++; $display("FAIL midcount_reset got dout=%b rise=%b tick=%b want 0000/0000/0",
                      debouncedOutput, risePulse, sampleTick);
    end
    @(negedge masterClk);
    #1 reset = 1'b0;
    start = cyc;
    sbq.push_back('{dout: 4'b0100, rise: 4'b0100 & PM, fall: 4'b0000, lo: start + 12, hi: start + 12});
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midcount_timeout got pending=%0d want 0", sbq.size()); sbq.delete(); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_back_to_back();
    test_reset_midcount();
    repeat (4) @(negedge masterClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/input_debounce_filter.md
Name: input_debounce_filter

Overview:
- Per-bit debounce/glitch filter for raw satellite digital inputs (sensors, push buttons).
- Sits directly upstream of the latch register: its debounced outputs drive the latch register's latchInput bus.
- Synchronises each async input, samples it on a prescaled tick and changes the output only after N consecutive equal samples.
- Optional per-bit rise/fall edge pulses.

Parameters:
- WIDTH, 8, number of input channels.
- CLK_DIV, 3000, masterClk cycles per sample tick (100 us at 30 MHz); legal range 1..65535.
- STABLE_SAMPLES, 8, consecutive differing samples needed to accept a new level; legal range 1..255.
- INIT_LEVEL, 0, level (0/1) loaded into every channel's synchroniser and output at reset.

Ports:
- masterClk  input  1  master clock, >~30 MHz; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- rawInput  input  WIDTH  asynchronous raw inputs.
- debouncedOutput  output  WIDTH  filtered level, registered; feeds latch register latchInput.
- risePulse  output  WIDTH  one-cycle pulse when debouncedOutput[i] goes 0->1.
- fallPulse  output  WIDTH  one-cycle pulse when debouncedOutput[i] goes 1->0.
- sampleTick  output  1  one-cycle strobe marking each sample instant (debug/observability).

Behaviour:
- Reset (async, acts without clock edge):
  - synchroniser stages = INIT_LEVEL.
  - debouncedOutput = {WIDTH{INIT_LEVEL}}.
  - per-bit counters = 0, prescaler = 0.
  - risePulse = fallPulse = 0, sampleTick = 0.
- Synchroniser: two flops per bit (raw -> meta -> sync), clocked every masterClk cycle regardless of tick.
- Prescaler:
  - counts 0..CLK_DIV-1, wraps to 0.
  - sampleTick = 1 for exactly the cycle where prescaler == CLK_DIV-1.
  - CLK_DIV=1 gives sampleTick every cycle.
- Per-bit filter, evaluated only on cycles with sampleTick=1:
  - sync[i] == debouncedOutput[i]: counter[i] <= 0.
  - otherwise, if counter[i]+1 == STABLE_SAMPLES: debouncedOutput[i] <= sync[i], counter[i] <= 0.
  - otherwise: counter[i] <= counter[i]+1.
- Non-tick cycles: counters and outputs hold; input activity between ticks is invisible to the filter.
- A single matching sample in a differing run restarts the count, so output changes only after STABLE_SAMPLES consecutive differing samples.
- Counter width = clog2(STABLE_SAMPLES+1); no overflow is possible.
- STABLE_SAMPLES=1: output takes the sampled level on the first tick after the change reaches the sync stage.
- Latency from a clean rawInput edge to debouncedOutput change:
  - minimum 2 + (STABLE_SAMPLES-1)*CLK_DIV + 1 cycles.
  - maximum 2 + STABLE_SAMPLES*CLK_DIV cycles.
- Edge pulses:
  - registered in the same clock edge that updates debouncedOutput.
  - high for exactly one cycle.
  - risePulse[i] and fallPulse[i] are never both 1.
- Channels are fully independent; simultaneous changes on several bits update in the same cycle.
- Reset asserted mid-count discards partial counts; no pulse is generated by reset itself.
- Reset deassertion: the prescaler restarts from 0, so the first tick occurs CLK_DIV cycles later.

Optional Feature:
- Macro: INPUT_DEBOUNCE_EDGE_PULSE_EN.
- Defined: risePulse/fallPulse behave as specified above.
- Undefined:
  - edge-detect registers are not built.
  - risePulse and fallPulse are tied to constant 0.
  - debouncedOutput and sampleTick are unchanged.
  - ports remain present so instantiations do not change.

Test Plan:
- Common settings: WIDTH=4, CLK_DIV=4, STABLE_SAMPLES=3, INIT_LEVEL=0, macro defined unless stated.
- Reset assert without clock running -> debouncedOutput=4'b0000, pulses 0, sampleTick 0 immediately; deassert -> first sampleTick at 4th rising clock edge.
- rawInput[0] steps 0->1 and stays -> debouncedOutput[0]=1 within 11..14 cycles; risePulse=4'b0001 for exactly one cycle in the same cycle; bits 1..3 remain 0.
- rawInput[1] pulses high spanning 2 ticks then low -> debouncedOutput[1] stays 0 and risePulse[1] never asserts; repeat with high-low-high-high-high sample pattern -> output rises only after the final three consecutive highs.
- rawInput 4'b0000->4'b1100 in the same cycle -> debouncedOutput=4'b1100 in one cycle with risePulse=4'b1100; later 4'b1100->4'b0100 -> fallPulse=4'b1000 for one cycle.
- Reset asserted after 2 of 3 differing samples on bit 2 -> output 0 immediately; after release, bit 2 needs a full 3 fresh samples to change, no pulse from reset.
- Rebuild with INPUT_DEBOUNCE_EDGE_PULSE_EN undefined, rerun the rawInput[0] step scenario -> debouncedOutput timing identical, risePulse/fallPulse constant 0.
